// File: rtl/mem_access_stage_if.sv
// Data-memory request/response bus between the MEM stage (master) and data memory (slave).
interface mem_access_stage_if;
  logic        Dmem_Req_o;
  logic        Dmem_We_o;
  logic [31:0] Dmem_Addr_o;
  logic [31:0] Dmem_Wdata_o;
  logic [3:0]  Dmem_Be_o;
  logic        Dmem_Gnt_i;
  logic        Dmem_Rvalid_i;
  logic [31:0] Dmem_Rdata_i;
  logic        Dmem_Err_i;

  modport master (
    output Dmem_Req_o, Dmem_We_o, Dmem_Addr_o, Dmem_Wdata_o, Dmem_Be_o,
    input  Dmem_Gnt_i, Dmem_Rvalid_i, Dmem_Rdata_i, Dmem_Err_i
  );

  modport slave (
    input  Dmem_Req_o, Dmem_We_o, Dmem_Addr_o, Dmem_Wdata_o, Dmem_Be_o,
    output Dmem_Gnt_i, Dmem_Rvalid_i, Dmem_Rdata_i, Dmem_Err_i
  );
endinterface

// File: rtl/mem_access_stage.sv
// MEM stage: turns loads/stores into byte-enabled word requests, aligns/extends load data,
// and stalls upstream until each access completes or times out.
module mem_access_stage #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic                clk_i_MEM,
  input  logic                rst_i_MEM,
  input  logic [31:0]         Wt_Data_i_MEM,
  input  logic [4:0]          Wt_Addr_i_MEM,
  input  logic                Wt_Enable_i_MEM,
  input  logic [31:0]         Rd_Data2_i_MEM,
  input  logic [1:0]          Mem_Op_i_MEM,
  input  logic [1:0]          Mem_Size_i_MEM,
  input  logic                Mem_Unsigned_i_MEM,
  mem_access_stage_if.master  dmem,
  output logic                Stall_o_MEM,
  output logic [31:0]         Wt_Data_o_MEM,
  output logic [4:0]          Wt_Addr_o_MEM,
  output logic                Wt_Enable_o_MEM,
  output logic                Misalign_o_MEM,
  output logic                Bus_Err_o_MEM
);

  localparam int unsigned      CNT_W    = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       lat_off;
  logic [1:0]       lat_size;
  logic             lat_uns;
  logic             lat_wt_en;
  logic [4:0]       lat_wt_addr;
  logic [31:0]      cap_data;

  logic        is_load, is_store, is_mem, misalign_c, start_c, timeout_c;
  logic [3:0]  be_c;
  logic [31:0] wdata_c, shifted_c, load_ext_c;

  assign is_load   = (Mem_Op_i_MEM == 2'b01);
  assign is_store  = (Mem_Op_i_MEM == 2'b10);
  assign is_mem    = is_load | is_store;
  assign start_c   = (state == S_IDLE) && is_mem && !misalign_c;
  assign timeout_c = (cnt == CNT_LAST);

  // Request shaping from the incoming instruction
  always_comb begin
    misalign_c = 1'b0;
    be_c       = 4'b1111;
    wdata_c    = Rd_Data2_i_MEM;
    case (Mem_Size_i_MEM)
      2'b00: begin
        be_c    = 4'b0001 << Wt_Data_i_MEM[1:0];
        wdata_c = {4{Rd_Data2_i_MEM[7:0]}};
      end
      2'b01: begin
        misalign_c = Wt_Data_i_MEM[0];
        be_c       = 4'b0011 << Wt_Data_i_MEM[1:0];
        wdata_c    = {2{Rd_Data2_i_MEM[15:0]}};
      end
      2'b10:   misalign_c = |Wt_Data_i_MEM[1:0];
      default: misalign_c = 1'b1;
    endcase
  end

  // Load alignment and extension from the latched access attributes
  always_comb begin
    shifted_c  = dmem.Dmem_Rdata_i >> {lat_off, 3'b000};
    load_ext_c = shifted_c;
    case (lat_size)
      2'b00:   load_ext_c = lat_uns ? {24'd0, shifted_c[7:0]}
                                    : {{24{shifted_c[7]}}, shifted_c[7:0]};
      2'b01:   load_ext_c = lat_uns ? {16'd0, shifted_c[15:0]}
                                    : {{16{shifted_c[15]}}, shifted_c[15:0]};
      default: load_ext_c = shifted_c;
    endcase
  end

  // Stage outputs: passthrough in IDLE, write-back result in DONE
  always_comb begin
    Stall_o_MEM     = 1'b0;
    Misalign_o_MEM  = 1'b0;
    Wt_Data_o_MEM   = Wt_Data_i_MEM;
    Wt_Addr_o_MEM   = Wt_Addr_i_MEM;
    Wt_Enable_o_MEM = 1'b0;
    case (state)
      S_IDLE: begin
        if (!is_mem)         Wt_Enable_o_MEM = Wt_Enable_i_MEM;
        else if (misalign_c) Misalign_o_MEM  = 1'b1;
        else                 Stall_o_MEM     = 1'b1;
      end
      S_REQ, S_WAIT: Stall_o_MEM = 1'b1;
      S_DONE: begin
        Wt_Data_o_MEM   = cap_data;
        Wt_Addr_o_MEM   = lat_wt_addr;
        Wt_Enable_o_MEM = !dmem.Dmem_We_o && lat_wt_en && !Bus_Err_o_MEM;
      end
      default: ;
    endcase
  end

  // Access sequencer; bus request fields are held stable from IDLE until grant
  always_ff @(posedge clk_i_MEM) begin
    if (rst_i_MEM) begin
      state             <= S_IDLE;
      cnt               <= '0;
      cap_data          <= '0;
      lat_off           <= '0;
      lat_size          <= '0;
      lat_uns           <= 1'b0;
      lat_wt_en         <= 1'b0;
      lat_wt_addr       <= '0;
      Bus_Err_o_MEM     <= 1'b0;
      dmem.Dmem_Req_o   <= 1'b0;
      dmem.Dmem_We_o    <= 1'b0;
      dmem.Dmem_Addr_o  <= '0;
      dmem.Dmem_Wdata_o <= '0;
      dmem.Dmem_Be_o    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt           <= '0;
          Bus_Err_o_MEM <= 1'b0;
          if (start_c) begin
            state             <= S_REQ;
            dmem.Dmem_Req_o   <= 1'b1;
            dmem.Dmem_We_o    <= is_store;
            dmem.Dmem_Addr_o  <= {Wt_Data_i_MEM[31:2], 2'b00};
            dmem.Dmem_Wdata_o <= wdata_c;
            dmem.Dmem_Be_o    <= be_c;
            lat_off           <= Wt_Data_i_MEM[1:0];
            lat_size          <= Mem_Size_i_MEM;
            lat_uns           <= Mem_Unsigned_i_MEM;
            lat_wt_addr       <= Wt_Addr_i_MEM;
            lat_wt_en         <= Wt_Enable_i_MEM;
          end
        end
        S_REQ: begin
          cnt <= cnt + CNT_W'(1);
          if (dmem.Dmem_Gnt_i || timeout_c) dmem.Dmem_Req_o <= 1'b0;
          if (dmem.Dmem_Gnt_i && dmem.Dmem_We_o) begin
            state         <= S_DONE;
            Bus_Err_o_MEM <= dmem.Dmem_Err_i;
          end else if (timeout_c) begin
            state         <= S_DONE;
            Bus_Err_o_MEM <= 1'b1;
          end else if (dmem.Dmem_Gnt_i) begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          cnt <= cnt + CNT_W'(1);
          if (dmem.Dmem_Rvalid_i) begin
            state         <= S_DONE;
            cap_data      <= load_ext_c;
            Bus_Err_o_MEM <= dmem.Dmem_Err_i;
          end else if (timeout_c) begin
            state         <= S_DONE;
            Bus_Err_o_MEM <= 1'b1;
          end
        end
        S_DONE: begin
          state         <= S_IDLE;
          cnt           <= '0;
          Bus_Err_o_MEM <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized bench for mem_access_stage against an access-level timing/data model.
module tb_mem_access_stage;
  localparam int T = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] Wt_Data_i, Rd_Data2_i;
  logic [4:0]  Wt_Addr_i;
  logic        Wt_Enable_i, Mem_Unsigned_i;
  logic [1:0]  Mem_Op_i, Mem_Size_i;
  logic        Stall, Wt_Enable_o, Misalign, Bus_Err;
  logic [31:0] Wt_Data_o;
  logic [4:0]  Wt_Addr_o;

  mem_access_stage_if dm();

  mem_access_stage #(.TIMEOUT_CYC(T)) dut (
    .clk_i_MEM          (clk),
    .rst_i_MEM          (rst),
    .Wt_Data_i_MEM      (Wt_Data_i),
    .Wt_Addr_i_MEM      (Wt_Addr_i),
    .Wt_Enable_i_MEM    (Wt_Enable_i),
    .Rd_Data2_i_MEM     (Rd_Data2_i),
    .Mem_Op_i_MEM       (Mem_Op_i),
    .Mem_Size_i_MEM     (Mem_Size_i),
    .Mem_Unsigned_i_MEM (Mem_Unsigned_i),
    .dmem               (dm.master),
    .Stall_o_MEM        (Stall),
    .Wt_Data_o_MEM      (Wt_Data_o),
    .Wt_Addr_o_MEM      (Wt_Addr_o),
    .Wt_Enable_o_MEM    (Wt_Enable_o),
    .Misalign_o_MEM     (Misalign),
    .Bus_Err_o_MEM      (Bus_Err)
  );

  // Expected values for the current cycle, written by the driver
  logic        chk_on = 1'b0;
  logic        e_stall, e_req, e_mis, e_berr, e_en, e_we, e_chk_data, e_chk_waddr, e_lit;
  logic [31:0] e_data, e_addr, e_wd;
  logic [4:0]  e_waddr;
  logic [3:0]  e_be;
  int          e_lit_stall, e_lit_req;
  int          n_vec = 0, n_err = 0;
  int          stall_run = 0, req_run = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h @%0t", nm, act, exp, $time);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      chk("stall", 32'(Stall), 32'(e_stall));
      chk("req", 32'(dm.Dmem_Req_o), 32'(e_req));
      chk("misalign", 32'(Misalign), 32'(e_mis));
      chk("bus_err", 32'(Bus_Err), 32'(e_berr));
      chk("wt_en", 32'(Wt_Enable_o), 32'(e_en));
      if (e_req) begin
        chk("we", 32'(dm.Dmem_We_o), 32'(e_we));
        chk("addr", dm.Dmem_Addr_o, e_addr);
        chk("be", 32'(dm.Dmem_Be_o), 32'(e_be));
        if (e_we) chk("wdata", dm.Dmem_Wdata_o, e_wd);
      end
      if (e_chk_data)  chk("wt_data", Wt_Data_o, e_data);
      if (e_chk_waddr) chk("wt_addr", 32'(Wt_Addr_o), 32'(e_waddr));
      if (e_lit) begin
        chk("stall_cycles", 32'(stall_run), 32'(e_lit_stall));
        chk("req_cycles", 32'(req_run), 32'(e_lit_req));
      end
    end
    if (!Stall) begin
      stall_run = 0;
      req_run   = 0;
    end else begin
      stall_run++;
      if (dm.Dmem_Req_o) req_run++;
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic clr_exp;
    e_stall = 1'b0; e_req = 1'b0; e_mis = 1'b0; e_berr = 1'b0; e_en = 1'b0; e_we = 1'b0;
    e_chk_data = 1'b0; e_chk_waddr = 1'b0; e_lit = 1'b0;
  endtask

  // Memory-side signals that must be ignored outside their owning state
  task automatic noise;
    dm.Dmem_Gnt_i    = 1'($urandom);
    dm.Dmem_Rvalid_i = 1'($urandom);
    dm.Dmem_Err_i    = 1'($urandom);
    dm.Dmem_Rdata_i  = $urandom;
  endtask

  // One instruction: g = REQ cycles before grant, r = WAIT cycles before rvalid
  task automatic run_instr(input logic [1:0] op, input logic [1:0] size, input logic uns,
                           input logic [31:0] a, input logic [31:0] d2, input logic [4:0] wa,
                           input logic wen, input int g, input int r, input logic errb,
                           input logic [31:0] rdat, input logic lit_on, input logic [31:0] lit_data,
                           input logic [3:0] lit_be, input logic [31:0] lit_wd,
                           input int lit_stall, input int lit_req);
    logic        is_mem, mis, err;
    int          nb, off, c, done_k;
    logic [3:0]  be;
    logic [31:0] wd, ld;
    is_mem = (op == 2'b01) || (op == 2'b10);
    mis    = (size == 2'b11) || (size == 2'b01 && a[0]) || (size == 2'b10 && a[1:0] != 2'b00);
    nb     = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    off    = int'(a[1:0]);
    be = '0;
    wd = '0;
    for (int i = 0; i < 4; i++) begin
      if (i >= off && i < off + nb) be[i] = 1'b1;
      wd[8*i +: 8] = d2[8*(i % nb) +: 8];
    end
    ld = rdat >> (8 * off);
    if (nb == 1) begin
      ld = ld & 32'h0000_00FF;
      if (!uns && ld[7]) ld = ld | 32'hFFFF_FF00;
    end else if (nb == 2) begin
      ld = ld & 32'h0000_FFFF;
      if (!uns && ld[15]) ld = ld | 32'hFFFF_0000;
    end
    c      = (op == 2'b10) ? g : g + 1 + r;
    done_k = (c < T - 1) ? c : T - 1;
    err    = (c > T - 1) || errb;
    if (lit_on) begin
      be = lit_be;
      wd = lit_wd;
      ld = lit_data;
    end

    Mem_Op_i = op; Mem_Size_i = size; Mem_Unsigned_i = uns; Wt_Data_i = a;
    Rd_Data2_i = d2; Wt_Addr_i = wa; Wt_Enable_i = wen;
    noise();
    clr_exp();
    if (!is_mem) begin
      e_en = wen; e_data = a; e_waddr = wa; e_chk_data = 1'b1; e_chk_waddr = 1'b1;
      step();
      return;
    end
    if (mis) begin
      e_mis = 1'b1;
      step();
      return;
    end
    e_stall = 1'b1;
    step();
    for (int k = 0; k <= done_k; k++) begin
      noise();
      if (k <= g) dm.Dmem_Gnt_i = (k == g);
      if (op == 2'b01 && k > g) dm.Dmem_Rvalid_i = (k == c);
      if (k == c) begin
        dm.Dmem_Err_i   = errb;
        dm.Dmem_Rdata_i = rdat;
      end
      clr_exp();
      e_stall = 1'b1; e_req = (k <= g); e_we = (op == 2'b10);
      e_addr = {a[31:2], 2'b00}; e_be = be; e_wd = wd;
      step();
    end
    noise();
    clr_exp();
    e_berr = err;
    e_en = (op == 2'b01) && wen && !err;
    e_chk_data = (op == 2'b01) && !err; e_data = ld;
    e_chk_waddr = 1'b1; e_waddr = wa;
    e_lit = lit_on; e_lit_stall = lit_stall; e_lit_req = lit_req;
    step();
  endtask

  initial begin
    logic [1:0]  op, sz;
    logic [31:0] a;
    int          g, r;
    rst = 1'b1;
    Mem_Op_i = 2'b00; Mem_Size_i = 2'b00; Mem_Unsigned_i = 1'b0; Wt_Data_i = '0;
    Rd_Data2_i = '0; Wt_Addr_i = '0; Wt_Enable_i = 1'b0;
    dm.Dmem_Gnt_i = 1'b0; dm.Dmem_Rvalid_i = 1'b0; dm.Dmem_Rdata_i = '0; dm.Dmem_Err_i = 1'b0;
    clr_exp();
    step();
    chk_on = 1'b1;
    step();
    rst = 1'b0;

    run_instr(2'b00, 2'b10, 1'b0, 32'h1234_5678, 32'h0, 5'd5, 1'b1, 0, 0, 1'b0, 32'h0,
              1'b0, 32'h0, 4'h0, 32'h0, 0, 0);
    run_instr(2'b01, 2'b10, 1'b0, 32'h0000_0100, 32'h0, 5'd7, 1'b1, 0, 0, 1'b0, 32'hDEAD_BEEF,
              1'b1, 32'hDEAD_BEEF, 4'b1111, 32'h0, 3, 1);
    run_instr(2'b01, 2'b00, 1'b0, 32'h0000_0103, 32'h0, 5'd8, 1'b1, 0, 0, 1'b0, 32'h8012_3456,
              1'b1, 32'hFFFF_FF80, 4'b1000, 32'h0, 3, 1);
    run_instr(2'b01, 2'b00, 1'b1, 32'h0000_0103, 32'h0, 5'd8, 1'b1, 0, 0, 1'b0, 32'h8012_3456,
              1'b1, 32'h0000_0080, 4'b1000, 32'h0, 3, 1);
    run_instr(2'b10, 2'b01, 1'b0, 32'h0000_0202, 32'h0000_ABCD, 5'd9, 1'b1, 4, 0, 1'b0, 32'h0,
              1'b1, 32'h0, 4'b1100, 32'hABCD_ABCD, 6, 5);
    run_instr(2'b01, 2'b10, 1'b0, 32'h0000_0101, 32'h0, 5'd3, 1'b1, 0, 0, 1'b0, 32'h0,
              1'b0, 32'h0, 4'h0, 32'h0, 0, 0);
    run_instr(2'b01, 2'b10, 1'b0, 32'h0000_0400, 32'h0, 5'd4, 1'b1, 0, 100, 1'b0, 32'h0,
              1'b1, 32'h0, 4'b1111, 32'h0, 17, 1);
    run_instr(2'b10, 2'b10, 1'b0, 32'h0000_0300, 32'h55AA_1234, 5'd6, 1'b1, 2, 0, 1'b1, 32'h0,
              1'b0, 32'h0, 4'h0, 32'h0, 0, 0);

    repeat (300) begin
      op = 2'($urandom);
      sz = 2'($urandom);
      a  = $urandom;
      if ($urandom_range(0, 2) != 0) begin
        if (sz == 2'b01) a[0] = 1'b0;
        if (sz == 2'b10) a[1:0] = 2'b00;
      end
      g = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 20)) : int'($urandom_range(0, 3));
      r = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 20)) : int'($urandom_range(0, 3));
      run_instr(op, sz, 1'($urandom), a, $urandom, 5'($urandom), 1'($urandom), g, r,
                ($urandom_range(0, 7) == 0), $urandom, 1'b0, 32'h0, 4'h0, 32'h0, 0, 0);
    end

    // Reset during WAIT, then a late rvalid must not reach write-back
    Mem_Op_i = 2'b01; Mem_Size_i = 2'b10; Mem_Unsigned_i = 1'b0; Wt_Data_i = 32'h0000_0500;
    Wt_Addr_i = 5'd11; Wt_Enable_i = 1'b1;
    dm.Dmem_Gnt_i = 1'b0; dm.Dmem_Rvalid_i = 1'b0; dm.Dmem_Err_i = 1'b0;
    clr_exp(); e_stall = 1'b1;
    step();
    dm.Dmem_Gnt_i = 1'b1;
    clr_exp(); e_stall = 1'b1; e_req = 1'b1; e_we = 1'b0; e_addr = 32'h0000_0500; e_be = 4'b1111;
    step();
    dm.Dmem_Gnt_i = 1'b0; rst = 1'b1;
    clr_exp(); e_stall = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      Mem_Op_i = 2'b00; Wt_Data_i = 32'hCAFE_0000 + 32'(k); Wt_Addr_i = 5'd12; Wt_Enable_i = 1'b1;
      dm.Dmem_Rvalid_i = 1'b1; dm.Dmem_Rdata_i = 32'hBAD0_BAD0;
      clr_exp(); e_en = 1'b1; e_data = 32'hCAFE_0000 + 32'(k); e_chk_data = 1'b1;
      e_waddr = 5'd12; e_chk_waddr = 1'b1;
      step();
    end
    chk_on = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
